color_mask_localizer: RTL

Frame-level consumer of the per-pixel 2-bit color mask stream from the color-mask stage. It accepts one `colorEncoding` per valid cycle in raster order, tracks the pixel position, and accumulates, for each of the two target colors, the hit count and bounding box. At each frame end it publishes a registered paddle-position report: box, box center, and a found flag per color. Downstream paddle/game logic reads this report.

---
 rtl/color_mask_localizer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/color_mask_localizer.sv
// Frame-level localizer: accumulates per-color hit count and bounding box over a
// raster-order 2-bit mask stream and publishes a registered report at frame end.
module color_mask_localizer #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int COUNT_WIDTH = 19,
  parameter int MIN_COUNT   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             colorEncoding,
  input  logic                   in_valid,
  input  logic                   sof,
  output logic                   frame_valid,
  output logic                   found1,
  output logic                   found2,
  output logic [COUNT_WIDTH-1:0] count1,
  output logic [COUNT_WIDTH-1:0] count2,
  output logic [X_WIDTH-1:0]     xMin1,
  output logic [X_WIDTH-1:0]     xMax1,
  output logic [X_WIDTH-1:0]     xMin2,
  output logic [X_WIDTH-1:0]     xMax2,
  output logic [Y_WIDTH-1:0]     yMin1,
  output logic [Y_WIDTH-1:0]     yMax1,
  output logic [Y_WIDTH-1:0]     yMin2,
  output logic [Y_WIDTH-1:0]     yMax2,
  output logic [X_WIDTH-1:0]     xCenter1,
  output logic [X_WIDTH-1:0]     xCenter2,
  output logic [Y_WIDTH-1:0]     yCenter1,
  output logic [Y_WIDTH-1:0]     yCenter2
);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  localparam logic [X_WIDTH-1:0]     X_LAST  = X_WIDTH'(IMG_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0]     Y_LAST  = Y_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MIN = COUNT_WIDTH'(MIN_COUNT);

  state_t state, state_next;
  logic   take, start, last;

  logic [X_WIDTH-1:0] x, cur_x;
  logic [Y_WIDTH-1:0] y, cur_y;

  // Index 0 is color 1 (mask bit 1), index 1 is color 2 (mask bit 0).
  logic [1:0][COUNT_WIDTH-1:0] cnt, cnt_upd, rep_cnt;
  logic [1:0][X_WIDTH-1:0]     xmin, xmax, xmin_upd, xmax_upd, rep_xmin, rep_xmax, rep_xc;
  logic [1:0][Y_WIDTH-1:0]     ymin, ymax, ymin_upd, ymax_upd, rep_ymin, rep_ymax, rep_yc;
  logic [1:0][X_WIDTH:0]       xsum;
  logic [1:0][Y_WIDTH:0]       ysum;
  logic [1:0]                  rep_found;

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) state <= WAIT_SOF;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) state_next = ACTIVE;
    if (last)  state_next = WAIT_SOF;
  end

  // A valid sof pixel always restarts at (0,0), even mid-frame.
  always_comb begin
    start = in_valid && sof;
    take  = in_valid && (sof || state == ACTIVE);
    cur_x = sof ? '0 : x;
    cur_y = sof ? '0 : y;
    last  = take && (cur_x == X_LAST) && (cur_y == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (take) begin
      if (last) begin
        x <= '0;
        y <= '0;
      end else if (cur_x == X_LAST) begin
        x <= '0;
        y <= cur_y + 1'b1;
      end else begin
        x <= cur_x + 1'b1;
        y <= cur_y;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      // NOTE: every comb output gets a default before any condition, so no latch is inferred.
      cnt_upd[c]  = start ? '0 : cnt[c];
      xmin_upd[c] = start ? '1 : xmin[c];
      xmax_upd[c] = start ? '0 : xmax[c];
      ymin_upd[c] = start ? '1 : ymin[c];
      ymax_upd[c] = start ? '0 : ymax[c];
      if (take && colorEncoding[1-c]) begin
        if (cnt_upd[c] != '1)     cnt_upd[c]  = cnt_upd[c] + 1'b1;
        if (cur_x < xmin_upd[c])  xmin_upd[c] = cur_x;
        if (cur_x > xmax_upd[c])  xmax_upd[c] = cur_x;
        if (cur_y < ymin_upd[c])  ymin_upd[c] = cur_y;
        if (cur_y > ymax_upd[c])  ymax_upd[c] = cur_y;
      end
      xsum[c] = {1'b0, xmin_upd[c]} + {1'b0, xmax_upd[c]};
      ysum[c] = {1'b0, ymin_upd[c]} + {1'b0, ymax_upd[c]};
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset || (take && last)) begin
        cnt[c]  <= '0;
        xmin[c] <= '1;
        xmax[c] <= '0;
        ymin[c] <= '1;
        ymax[c] <= '0;
      end else if (take) begin
        cnt[c]  <= cnt_upd[c];
        xmin[c] <= xmin_upd[c];
        xmax[c] <= xmax_upd[c];
        ymin[c] <= ymin_upd[c];
        ymax[c] <= ymax_upd[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_valid <= 1'b0;
      rep_found   <= '0;
      rep_cnt     <= '0;
      rep_xmin    <= '0;
      rep_xmax    <= '0;
      rep_ymin    <= '0;
      rep_ymax    <= '0;
      rep_xc      <= '0;
      rep_yc      <= '0;
    end else begin
      frame_valid <= last;
      if (last) begin
        for (int c = 0; c < 2; c++) begin
          rep_cnt[c]   <= cnt_upd[c];
          rep_found[c] <= (cnt_upd[c] >= CNT_MIN);
          if (cnt_upd[c] == '0) begin
            rep_xmin[c] <= '0;
            rep_xmax[c] <= '0;
            rep_ymin[c] <= '0;
            rep_ymax[c] <= '0;
            rep_xc[c]   <= '0;
            rep_yc[c]   <= '0;
          end else begin
            rep_xmin[c] <= xmin_upd[c];
            rep_xmax[c] <= xmax_upd[c];
            rep_ymin[c] <= ymin_upd[c];
            rep_ymax[c] <= ymax_upd[c];
            rep_xc[c]   <= xsum[c][X_WIDTH:1];
            rep_yc[c]   <= ysum[c][Y_WIDTH:1];
          end
        end
      end
    end
  end

  assign found1   = rep_found[0];
  assign found2   = rep_found[1];
  assign count1   = rep_cnt[0];
  assign count2   = rep_cnt[1];
  assign xMin1    = rep_xmin[0];
  assign xMax1    = rep_xmax[0];
  assign xMin2    = rep_xmin[1];
  assign xMax2    = rep_xmax[1];
  assign yMin1    = rep_ymin[0];
  assign yMax1    = rep_ymax[0];
  assign yMin2    = rep_ymin[1];
  assign yMax2    = rep_ymax[1];
  assign xCenter1 = rep_xc[0];
  assign xCenter2 = rep_xc[1];
  assign yCenter1 = rep_yc[0];
  assign yCenter2 = rep_yc[1];

endmodule
